// File: rtl/display_window_fx.sv
`default_nettype none
// ============================================================================
// Module   : display_window_fx
// Brief    : Places a zoomed RAM image on the VGA raster with a frame-stepped
//            fade-in/fade-out and an optional 2-pixel border around it.
// Revision : 1.0  initial release
// ============================================================================
module display_window_fx #(
  parameter int         IMG_W      = 200,
  parameter int         IMG_H      = 150,
  parameter int         ADDR_W     = 15,
  parameter logic [7:0] SHOW_STATE = 8'h03
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [7:0]        state,
  input  logic [9:0]        start_row,
  input  logic [9:0]        start_col,
  input  logic [1:0]        scale,
  input  logic              frame_sync,
  input  logic              border_en,
  input  logic [11:0]       border_color,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       pixel_data,
  output logic              display_valid,
  output logic [11:0]       VGA_RGB,
  output logic              fade_busy
);

  localparam logic [1:0]  c_ST_IDLE     = 2'd0;
  localparam logic [1:0]  c_ST_FADE_IN  = 2'd1;
  localparam logic [1:0]  c_ST_SHOW     = 2'd2;
  localparam logic [1:0]  c_ST_FADE_OUT = 2'd3;
  localparam logic [4:0]  c_LVL_MAX     = 5'd16;
  localparam logic [12:0] c_IMG_W       = 13'(IMG_W);
  localparam logic [12:0] c_IMG_H       = 13'(IMG_H);

  // ---------------------------------------------------------------- stage 0
  logic [1:0]        w_sh;
  logic [12:0]       w_x, w_y, w_col0, w_row0, w_col1, w_row1, w_wd, w_hd;
  logic              w_in_x, w_in_y, w_near_x, w_near_y;
  logic              w_in_img, w_in_border, w_show;
  logic [11:0]       w_dx, w_dy, w_dx_s, w_dy_s;
  logic [ADDR_W-1:0] w_addr;

  assign w_sh   = (scale == 2'd0) ? 2'd0 : (scale == 2'd1) ? 2'd1 : 2'd2;

  // 13-bit coordinates so window edges past 4095 or below 0 never wrap
  assign w_x    = {1'b0, xpos};
  assign w_y    = {1'b0, ypos};
  assign w_col0 = {3'b000, start_col};
  assign w_row0 = {3'b000, start_row};
  assign w_wd   = c_IMG_W << w_sh;
  assign w_hd   = c_IMG_H << w_sh;
  assign w_col1 = w_col0 + w_wd;
  assign w_row1 = w_row0 + w_hd;

  assign w_in_x   = (w_x >= w_col0) && (w_x < w_col1);
  assign w_in_y   = (w_y >= w_row0) && (w_y < w_row1);
  assign w_near_x = (w_x + 13'd2 >= w_col0) && (w_x < w_col1 + 13'd2);
  assign w_near_y = (w_y + 13'd2 >= w_row0) && (w_y < w_row1 + 13'd2);

  assign w_in_img    = w_in_x && w_in_y;
  assign w_in_border = border_en && w_near_x && w_near_y && !w_in_img;
  assign w_show      = (state == SHOW_STATE);

  assign w_dx   = xpos - {2'b00, start_col};
  assign w_dy   = ypos - {2'b00, start_row};
  assign w_dx_s = w_dx >> w_sh;
  assign w_dy_s = w_dy >> w_sh;
  assign w_addr = ADDR_W'(w_dy_s) * ADDR_W'(IMG_W) + ADDR_W'(w_dx_s);

  // ---------------------------------------------- qualifier pipeline (2 deep)
  logic        r_img1, r_img2, r_brd1, r_brd2;
  logic [11:0] r_bcol1, r_bcol2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr <= '0;
      r_img1  <= 1'b0;
      r_img2  <= 1'b0;
      r_brd1  <= 1'b0;
      r_brd2  <= 1'b0;
      r_bcol1 <= 12'h000;
      r_bcol2 <= 12'h000;
    end else begin
      rd_addr <= w_in_img ? w_addr : '0;
      r_img1  <= w_in_img;
      r_brd1  <= w_in_border && w_show;
      r_bcol1 <= border_color;
      r_img2  <= r_img1;
      r_brd2  <= r_brd1;
      r_bcol2 <= r_bcol1;
    end
  end

  // ---------------------------------------------------------------- fade FSM
  logic [1:0] r_fsm, w_fsm_nx;
  logic [4:0] r_lvl, w_lvl_nx;

  // The state-driven transition is resolved first; a coincident frame_sync
  // then steps lvl according to the state just entered.
  always_comb begin
    w_fsm_nx = r_fsm;
    w_lvl_nx = r_lvl;
    case (r_fsm)
      c_ST_IDLE:     if (w_show)  w_fsm_nx = c_ST_FADE_IN;
      c_ST_FADE_IN:  if (!w_show) w_fsm_nx = c_ST_FADE_OUT;
      c_ST_SHOW:     if (!w_show) w_fsm_nx = c_ST_FADE_OUT;
      c_ST_FADE_OUT: if (w_show)  w_fsm_nx = c_ST_FADE_IN;
      default:                    w_fsm_nx = c_ST_IDLE;
    endcase
    if (w_fsm_nx == c_ST_FADE_IN) begin
      if (frame_sync && (r_lvl != c_LVL_MAX)) w_lvl_nx = r_lvl + 5'd1;
      if (w_lvl_nx == c_LVL_MAX)              w_fsm_nx = c_ST_SHOW;
    end else if (w_fsm_nx == c_ST_FADE_OUT) begin
      if (frame_sync && (r_lvl != 5'd0))      w_lvl_nx = r_lvl - 5'd1;
      if (w_lvl_nx == 5'd0)                   w_fsm_nx = c_ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm <= c_ST_IDLE;
      r_lvl <= 5'd0;
    end else begin
      r_fsm <= w_fsm_nx;
      r_lvl <= w_lvl_nx;
    end
  end

  // ------------------------------------------------------------------ output
  function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [4:0] l);
    logic [7:0] p;
    p = {4'b0000, c} * {3'b000, l};
    return 4'(p >> 4);
  endfunction

  logic        w_fsm_on;
  logic [11:0] w_faded;

  assign w_fsm_on = (r_fsm != c_ST_IDLE);
  assign w_faded  = {fade_ch(pixel_data[11:8], r_lvl),
                     fade_ch(pixel_data[7:4],  r_lvl),
                     fade_ch(pixel_data[3:0],  r_lvl)};

  // pixel_data arrives one cycle after rd_addr, aligned with stage-2 qualifiers
  always_comb begin
    VGA_RGB = 12'h000;
    if (r_img2 && w_fsm_on) VGA_RGB = w_faded;
    else if (r_brd2)        VGA_RGB = r_bcol2;
  end

  assign display_valid = r_img2 && w_fsm_on;
  assign fade_busy     = (r_fsm == c_ST_FADE_IN) || (r_fsm == c_ST_FADE_OUT);

endmodule
`default_nettype wire

// File: doc/display_window_fx.md
DISPLAY_WINDOW_FX -- requirements
Module: display_window_fx

Interface
REQ-001 SHALL have parameter IMG_W, default 200: source image width in pixels, as stored in RAM.
REQ-002 SHALL have parameter IMG_H, default 150: source image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 15: RAM address width; IMG_W*IMG_H SHALL fit in 2^ADDR_W.
REQ-004 SHALL have parameter SHOW_STATE, default 8'h03: the system state in which the image is shown.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have ports xpos and ypos, input, 12 each: current VGA scan coordinates.
REQ-008 SHALL have port state, input, 8: current system state.
REQ-009 SHALL have ports start_row and start_col, input, 10 each: top-left corner of the window on screen.
REQ-010 SHALL have port scale, input, 2: zoom code; 0 = x1, 1 = x2, 2 = x4, 3 is treated as x4.
REQ-011 SHALL have port frame_sync, input, 1: one-cycle pulse at the start of each frame.
REQ-012 SHALL have ports border_en (input, 1) and border_color (input, 12): enable and colour of a 2-pixel border.
REQ-013 SHALL have port rd_addr, output, ADDR_W: pixel RAM read address.
REQ-014 SHALL have port pixel_data, input, 12: RAM read data, valid exactly 1 cycle after rd_addr.
REQ-015 SHALL have port display_valid, output, 1: the current VGA_RGB value lies inside the image area.
REQ-016 SHALL have port VGA_RGB, output, 12: RGB444 pixel to the VGA output.
REQ-017 SHALL have port fade_busy, output, 1: high while a fade is in progress.

Function
REQ-018 Zoom shift sh SHALL be 0, 1, 2 or 2 for scale codes 0, 1, 2, 3; the window size is Wd = IMG_W<<sh by Hd = IMG_H<<sh.
REQ-019 Stage 0 (the cycle xpos/ypos are presented): in_img SHALL be xpos in [start_col, start_col+Wd) and ypos in [start_row, start_row+Hd); all comparisons at 12 bits, with no wrap.
REQ-020 Stage 0 SHALL register rd_addr = ((ypos-start_row)>>sh)*IMG_W + ((xpos-start_col)>>sh) when in_img, otherwise 0.
REQ-021 in_border SHALL be true when the pixel is outside the image, within 2 pixels of its edge, and border_en=1; it SHALL be pipelined alongside in_img.
REQ-022 Total latency from xpos/ypos to VGA_RGB and display_valid SHALL be exactly 2 cycles; every qualifier SHALL be delayed to match.
REQ-023 The fade FSM SHALL have four states: IDLE, FADE_IN, SHOW and FADE_OUT.
REQ-024 The brightness level lvl SHALL be 5 bits, in the range 0..16.
REQ-025 IDLE SHALL move to FADE_IN when state==SHOW_STATE.
REQ-026 FADE_IN SHALL increment lvl by 1 on each frame_sync and move to SHOW when lvl reaches 16.
REQ-027 SHOW SHALL move to FADE_OUT when state!=SHOW_STATE.
REQ-028 FADE_OUT SHALL decrement lvl by 1 on each frame_sync and move to IDLE when lvl reaches 0.
REQ-029 If state returns to SHOW_STATE during FADE_OUT, the FSM SHALL move to FADE_IN and keep the current lvl; the mirror case (state leaves during FADE_IN) SHALL move to FADE_OUT.
REQ-030 lvl SHALL saturate at 0 and at 16, never wrapping.
REQ-031 The output colour for each 4-bit channel c SHALL be (c*lvl)>>4, a 9-bit product truncated to 4 bits; lvl=16 gives c unchanged.
REQ-032 VGA_RGB SHALL be the faded pixel_data when in_img and the FSM is not IDLE.
REQ-033 VGA_RGB SHALL be border_color, unfaded, when in_border and state==SHOW_STATE (sampled at stage 0).
REQ-034 In all other cases VGA_RGB SHALL be 12'h000.
REQ-035 display_valid SHALL be the delayed in_img ANDed with FSM!=IDLE.
REQ-036 fade_busy SHALL be 1 exactly in FADE_IN and FADE_OUT.
REQ-037 frame_sync coinciding with a state change SHALL take the transition first and apply the lvl step in the new state in the same cycle.

Reset
REQ-038 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE; lvl, rd_addr, VGA_RGB, display_valid, fade_busy and all pipeline qualifiers SHALL be set to 0.
REQ-039 A reset in the middle of a fade SHALL abort it immediately; output SHALL be black on the next cycle.

Verification
REQ-040 scale=0, start=(0,0), lvl=16, pixel (xpos 5, ypos 2) -> rd_addr=405 one cycle later, VGA_RGB=pixel_data and display_valid=1 two cycles later.
REQ-041 scale=1, xpos=start_col+399 -> in window; xpos=start_col+400 -> display_valid=0 and VGA_RGB=000.
REQ-042 state set to 03 from IDLE, then 16 frame_sync pulses -> lvl steps 1..16, FSM in SHOW, fade_busy falls; pixel FFF at lvl 8 -> 777.
REQ-043 state leaves 03 at lvl=16, after 5 frame_sync state returns to 03 -> FADE_IN resumes from 11, with no jump.
REQ-044 border_en=1, border_color=F00, xpos=start_col-1 inside the row span -> VGA_RGB=F00 and display_valid=0.
REQ-045 rst_n=0 during FADE_IN at lvl=7 -> next cycle VGA_RGB=000, fade_busy=0, FSM IDLE.
